// File: rtl/npc_wide_pkg.sv
// Shared types and constants for the npc_wide next-PC predictor.
package npc_wide_pkg;

  localparam logic [1:0]  BHT_RESET = 2'd2;
  localparam logic [15:0] LFSR_TAP  = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  typedef struct packed {
    logic        valid;
    logic [29:0] pc;
    logic [31:0] target;
    logic        call;
    logic        ret;
    logic        jmp;
  } btb_entry_t;

  // 2-bit saturating counter step; taken wins if both flags are set
  function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/npc_wide_lfsr.sv
// 16-bit Galois LFSR supplying the BTB replacement index; steps once per allocation.
module npc_wide_lfsr
  import npc_wide_pkg::*;
#(
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  output logic [IDX_W-1:0] idx_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        lfsr_q <= LFSR_SEED;
    else if (alloc_i) lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAP : 16'h0000);
  end

  assign idx_o = lfsr_q[IDX_W-1:0];

endmodule

// File: rtl/npc_wide.sv
// Same-cycle next-PC predictor for a FETCH_W-wide fetch block (BTB + 2-bit BHT + RAS).
// Optional gshare BHT indexing is enabled by defining NPC_GSHARE_EN.
module npc_wide
  import npc_wide_pkg::*;
#(
  parameter int unsigned FETCH_W           = 2,
  parameter int unsigned NUM_BTB_ENTRIES   = 32,
  parameter int unsigned NUM_BTB_ENTRIES_W = 5,
  parameter int unsigned NUM_BHT_ENTRIES   = 512,
  parameter int unsigned NUM_BHT_ENTRIES_W = 9,
  parameter int unsigned NUM_RAS_ENTRIES   = 8,
  parameter int unsigned NUM_RAS_ENTRIES_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               invalidate_i,
  input  logic               branch_request_i,
  input  logic               branch_is_taken_i,
  input  logic               branch_is_not_taken_i,
  input  logic [31:0]        branch_source_i,
  input  logic               branch_is_call_i,
  input  logic               branch_is_ret_i,
  input  logic               branch_is_jmp_i,
  input  logic [31:0]        branch_pc_i,
  input  logic [31:0]        pc_f_i,
  input  logic               pc_accept_i,
  output logic [31:0]        next_pc_f_o,
  output logic [FETCH_W-1:0] next_taken_f_o
);

  localparam int unsigned FETCH_W_LOG2 = $clog2(FETCH_W);
  localparam int unsigned HW           = NUM_BHT_ENTRIES_W;
  localparam int unsigned RAS_CNT_W    = NUM_RAS_ENTRIES_W + 1;
  localparam logic [31:0] BLOCK_BYTES  = 32'(4 * FETCH_W);
  localparam logic [31:0] BLOCK_MASK   = ~((32'd1 << (FETCH_W_LOG2 + 2)) - 32'd1);
  localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(NUM_RAS_ENTRIES);

  btb_entry_t                    btb_q [NUM_BTB_ENTRIES];
  logic [1:0]                    bht_q [NUM_BHT_ENTRIES];
  logic [31:0]                   ras_q [NUM_RAS_ENTRIES];
  logic [NUM_RAS_ENTRIES_W-1:0]  spec_idx_q, spec_idx_d, real_idx_q, real_idx_d;
  logic [RAS_CNT_W-1:0]          spec_cnt_q, spec_cnt_d, real_cnt_q, real_cnt_d;

  logic [31:0]                   block_base, slot, lane_pc, pred_lane_pc;
  logic [NUM_BTB_ENTRIES_W-1:0]  lane_idx, src_idx, alloc_idx;
  logic                          lane_hit, lane_taken, src_hit, alloc;
  logic                          pred_valid, pred_call, pred_ret;
  logic [1:0]                    lane_cnt;
  logic [HW-1:0]                 rd_hist, bht_wr_idx;
  logic                          ras_we;
  logic [NUM_RAS_ENTRIES_W-1:0]  ras_wr_idx;
  logic [31:0]                   ras_wr_data;

`ifdef NPC_GSHARE_EN
  logic [HW-1:0] spec_hist_q, real_hist_q;
  logic          cond_seen, cond_taken;

  // Speculative history follows accepted blocks; real history follows resolutions
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_hist_q <= '0;
      real_hist_q <= '0;
    end else begin
      if (branch_is_taken_i || branch_is_not_taken_i)
        real_hist_q <= {real_hist_q[HW-2:0], branch_is_taken_i};
      if (branch_request_i)
        spec_hist_q <= {real_hist_q[HW-2:0], branch_is_taken_i};
      else if (pc_accept_i && cond_seen)
        spec_hist_q <= {spec_hist_q[HW-2:0], cond_taken};
    end
  end

  assign rd_hist    = spec_hist_q;
  assign bht_wr_idx = branch_source_i[2 +: HW] ^ (branch_request_i ? real_hist_q : spec_hist_q);
`else
  assign rd_hist    = '0;
  assign bht_wr_idx = branch_source_i[2 +: HW];
`endif

  // Lane scan: first taken lane at or after the fetch slot selects the next PC
  always_comb begin
    block_base     = pc_f_i & BLOCK_MASK;
    slot           = (pc_f_i - block_base) >> 2;
    next_pc_f_o    = block_base + BLOCK_BYTES;
    next_taken_f_o = '0;
    pred_valid     = 1'b0;
    pred_call      = 1'b0;
    pred_ret       = 1'b0;
    pred_lane_pc   = '0;
    lane_pc        = '0;
    lane_idx       = '0;
    lane_hit       = 1'b0;
    lane_taken     = 1'b0;
    lane_cnt       = '0;
`ifdef NPC_GSHARE_EN
    cond_seen      = 1'b0;
    cond_taken     = 1'b0;
`endif
    for (int k = 0; k < FETCH_W; k++) begin
      lane_pc  = block_base + 32'(4 * k);
      lane_hit = 1'b0;
      lane_idx = '0;
      for (int e = NUM_BTB_ENTRIES - 1; e >= 0; e--) begin
        if (btb_q[e].valid && btb_q[e].pc == lane_pc[31:2]) begin
          lane_hit = 1'b1;
          lane_idx = NUM_BTB_ENTRIES_W'(e);
        end
      end
      lane_cnt = bht_q[lane_pc[2 +: HW] ^ rd_hist];
      // A return is only predicted when the stack has something to pop
      if (btb_q[lane_idx].ret) lane_taken = (spec_cnt_q != '0);
      else                     lane_taken = btb_q[lane_idx].jmp || lane_cnt[1];
      if (!pred_valid && lane_hit && 32'(k) >= slot) begin
`ifdef NPC_GSHARE_EN
        if (!btb_q[lane_idx].jmp && !btb_q[lane_idx].ret && !cond_seen) begin
          cond_seen  = 1'b1;
          cond_taken = lane_taken;
        end
`endif
        if (lane_taken) begin
          pred_valid        = 1'b1;
          pred_call         = btb_q[lane_idx].call;
          pred_ret          = btb_q[lane_idx].ret;
          pred_lane_pc      = lane_pc;
          next_taken_f_o[k] = 1'b1;
          next_pc_f_o       = btb_q[lane_idx].ret ? ras_q[spec_idx_q] : btb_q[lane_idx].target;
        end
      end
    end
  end

  // RAS pointers: resolution resyncs the speculative copy and beats fetch activity
  always_comb begin
    real_idx_d  = real_idx_q;
    real_cnt_d  = real_cnt_q;
    spec_idx_d  = spec_idx_q;
    spec_cnt_d  = spec_cnt_q;
    ras_we      = 1'b0;
    ras_wr_idx  = '0;
    ras_wr_data = '0;
    if (branch_request_i) begin
      if (branch_is_call_i) begin
        real_idx_d  = real_idx_q + NUM_RAS_ENTRIES_W'(1);
        real_cnt_d  = (real_cnt_q == RAS_FULL) ? real_cnt_q : real_cnt_q + RAS_CNT_W'(1);
        ras_we      = 1'b1;
        ras_wr_idx  = real_idx_d;
        ras_wr_data = branch_source_i + 32'd4;
      end else if (branch_is_ret_i && real_cnt_q != '0) begin
        real_idx_d = real_idx_q - NUM_RAS_ENTRIES_W'(1);
        real_cnt_d = real_cnt_q - RAS_CNT_W'(1);
      end
      spec_idx_d = real_idx_d;
      spec_cnt_d = real_cnt_d;
    end else if (pc_accept_i && pred_valid) begin
      if (pred_call) begin
        spec_idx_d  = spec_idx_q + NUM_RAS_ENTRIES_W'(1);
        spec_cnt_d  = (spec_cnt_q == RAS_FULL) ? spec_cnt_q : spec_cnt_q + RAS_CNT_W'(1);
        ras_we      = 1'b1;
        ras_wr_idx  = spec_idx_d;
        ras_wr_data = pred_lane_pc + 32'd4;
      end else if (pred_ret) begin
        spec_idx_d = spec_idx_q - NUM_RAS_ENTRIES_W'(1);
        spec_cnt_d = spec_cnt_q - RAS_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      real_idx_q <= '0;
      real_cnt_q <= '0;
      spec_idx_q <= '0;
      spec_cnt_q <= '0;
      for (int i = 0; i < NUM_RAS_ENTRIES; i++) ras_q[i] <= '0;
    end else begin
      real_idx_q <= real_idx_d;
      real_cnt_q <= real_cnt_d;
      spec_idx_q <= spec_idx_d;
      spec_cnt_q <= spec_cnt_d;
      if (ras_we) ras_q[ras_wr_idx] <= ras_wr_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
    end else if (branch_is_taken_i || branch_is_not_taken_i) begin
      bht_q[bht_wr_idx] <= bht_step(bht_q[bht_wr_idx], branch_is_taken_i);
    end
  end

  // BTB lookup of the resolved branch
  always_comb begin
    src_hit = 1'b0;
    src_idx = '0;
    for (int e = NUM_BTB_ENTRIES - 1; e >= 0; e--) begin
      if (btb_q[e].valid && btb_q[e].pc == branch_source_i[31:2]) begin
        src_hit = 1'b1;
        src_idx = NUM_BTB_ENTRIES_W'(e);
      end
    end
  end

  assign alloc = branch_request_i && !src_hit;

  npc_wide_lfsr #(.IDX_W(NUM_BTB_ENTRIES_W)) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .alloc_i (alloc),
    .idx_o   (alloc_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_q[i] <= '0;
    end else if (invalidate_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (branch_request_i) begin
      if (src_hit) begin
        btb_q[src_idx].call <= branch_is_call_i;
        btb_q[src_idx].ret  <= branch_is_ret_i;
        btb_q[src_idx].jmp  <= branch_is_jmp_i;
        if (branch_is_taken_i) btb_q[src_idx].target <= branch_pc_i;
      end else begin
        btb_q[alloc_idx] <= '{valid: 1'b1, pc: branch_source_i[31:2], target: branch_pc_i,
                              call: branch_is_call_i, ret: branch_is_ret_i, jmp: branch_is_jmp_i};
      end
    end
  end

endmodule
